// File: rtl/block_memory.sv
`default_nettype none
// ============================================================================
// Module      : block_memory
// Description : Line-granular storage with a fixed, programmable access
//               latency. One request at a time: accepted in IDLE, completed
//               DELAY cycles later, read data returned with a one-cycle
//               valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module block_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 1024,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int c_DATA_W = BLOCK_SIZE * 8;
  localparam int c_IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int c_CNT_W  = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(DELAY - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_IDX_W-1:0]   r_index;
  logic                 r_is_write;
  logic [c_DATA_W-1:0]  r_din;

  // Storage powers up cleared and is deliberately left untouched by reset.
  logic [c_DATA_W-1:0]  r_mem [NUM_LINES] = '{default: '0};

  logic                 w_accept;
  logic                 w_complete;
  logic [c_IDX_W-1:0]   w_index;
  logic                 w_unused_addr;

  // Exactly one of read/write must be requested; anything else is dropped.
  assign w_accept   = is_input_valid && (r_state == S_IDLE) && (mem_read ^ mem_write);
  assign w_complete = (r_state == S_BUSY) && (r_count == '0);
  assign w_index    = addr[c_IDX_W-1:0];
  // Upper address bits are ignored so addresses wrap modulo NUM_LINES.
  assign w_unused_addr = ^addr[31:c_IDX_W];

  assign mem_ready = (r_state == S_IDLE);

  // Request sequencing: latch on accept, count down DELAY cycles, complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      is_output_valid <= 1'b0;
      dout            <= '0;
    end else begin
      is_output_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_index    <= w_index;
            r_is_write <= mem_write;
            r_din      <= din;
            r_count    <= c_LOAD;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_state <= S_IDLE;
            if (!r_is_write) begin
              dout            <= r_mem[r_index];
              is_output_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write commit on the completion edge; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!reset && w_complete && r_is_write) begin
      r_mem[r_index] <= r_din;
    end
  end

endmodule
`default_nettype wire

// File: doc/block_memory.md
BLOCK_MEMORY -- requirements
Module: block_memory

Interface
REQ-001 Parameter BLOCK_SIZE, default 16: line size in bytes; data ports are BLOCK_SIZE*8 bits wide.
REQ-002 Parameter NUM_LINES, default 1024: storage depth in lines; power of two.
REQ-003 Parameter DELAY, default 50: access latency in cycles; legal range is 1 or greater.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 is_input_valid  input  1  a request is present this cycle.
REQ-007 addr  input  32  line address; the byte address is already shifted right by log2(BLOCK_SIZE).
REQ-008 mem_read  input  1  the request is a line read.
REQ-009 mem_write  input  1  the request is a line write.
REQ-010 din  input  BLOCK_SIZE*8  write line data.
REQ-011 is_output_valid  output  1  dout holds completed read data; one-cycle pulse.
REQ-012 dout  output  BLOCK_SIZE*8  read line data.
REQ-013 mem_ready  output  1  the block can accept a request this cycle.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-015 mem_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 A request SHALL be accepted on a rising edge when all of the following hold: is_input_valid=1, state is IDLE, and exactly one of mem_read/mem_write is 1.
REQ-017 A request with both mem_read and mem_write, or with neither, SHALL be ignored: no state change and no storage change.
REQ-018 A request presented while the state is BUSY SHALL be ignored; the requester must hold it until mem_ready=1.
REQ-019 On acceptance, the block SHALL latch addr, op and din, load the latency counter with DELAY-1, and move to BUSY.
REQ-020 After acceptance, inputs SHALL be don't-care until completion.
REQ-021 In BUSY, each edge with counter≠0 SHALL decrement the counter.
REQ-022 In BUSY, the edge with counter=0 SHALL complete the access and return the state to IDLE.
REQ-023 The block SHALL therefore stay in BUSY for exactly DELAY cycles.
REQ-024 Read completion SHALL register storage[latched index] into dout and drive is_output_valid=1 for the following single cycle.
REQ-025 Write completion SHALL write the latched din to storage[latched index] and SHALL NOT assert is_output_valid.
REQ-026 The line index SHALL be addr[log2(NUM_LINES)-1:0]; upper address bits SHALL be ignored, so addresses wrap modulo NUM_LINES.
REQ-027 dout SHALL hold the last read data until the next read completes; writes SHALL NOT alter dout.
REQ-028 The completion cycle SHALL have mem_ready=1, so a new request can be accepted in the same cycle that is_output_valid=1 (back-to-back operation).
REQ-029 A read issued after a write completes to the same index SHALL return the written data.
REQ-030 With DELAY=1, the block SHALL spend one cycle in BUSY; read data SHALL be valid two edges after the accepting edge's cycle began.

Reset
REQ-031 When reset=1 at an edge, the block SHALL set: state=IDLE, counter=0, is_output_valid=0, dout=0, mem_ready=1 from the next cycle.
REQ-032 Reset during BUSY SHALL abort the access; a pending write SHALL NOT be committed.
REQ-033 Storage contents SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Verification (DELAY=4, BLOCK_SIZE=16, NUM_LINES=1024)
REQ-034 Write then read: write din=128'h0123..CDEF to addr 5, wait for mem_ready, read addr 5.
  - Required: mem_ready=0 for 4 cycles after each accept.
  - Required: is_output_valid pulses once with dout=128'h0123..CDEF.
REQ-035 Wrap-around: write 128'hAA..AA to addr 1029, read addr 5.
  - Required: dout=128'hAA..AA.
REQ-036 Illegal and busy requests:
  - mem_read=mem_write=1 in IDLE: mem_ready stays 1 and no pulse occurs.
  - A read presented mid-BUSY is ignored: exactly one completion, for the original request.
REQ-037 Back-to-back: hold is_input_valid=1 with alternating reads to addrs 0 and 1.
  - Required: a new accept in each completion cycle.
  - Required: is_output_valid pulses every 5 cycles with the correct data.
REQ-038 Reset mid-write: accept a write of 128'h55..55 to addr 9, assert reset in BUSY cycle 2, then read addr 9.
  - Required: dout=0.
  - Required: is_output_valid=0 and mem_ready=1 in the cycle after reset.
